lutram_fifo_ctrl: RTL and testbench

LUTRAM_FIFO_CTRL -- requirements
Module: lutram_fifo_ctrl

---
 rtl/lutram_fifo_ctrl.sv | 112 +++++++++++
 tb/tb_lutram_fifo_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lutram_fifo_ctrl.sv
// Purpose: 16x4 show-ahead FIFO controller driving an external TRELLIS_DPR16X4 LUTRAM.
// Latency: a word written at edge N is presented on out_data from the cycle after edge N.
// Backpressure: in_ready = !full from registered state only; out_valid = !empty; a refused write while full sets sticky ovf.
//
// Ports:
//   CLK, RST          sole clock (also the LUTRAM WCK) and synchronous active-high reset
//   flush             synchronous clear of pointers and count; ovf is kept
//   in_valid/in_ready/in_data     producer handshake and 4-bit write data
//   out_valid/out_ready/out_data  consumer handshake and 4-bit read data (from ram_do)
//   ram_wad/ram_di/ram_wre        LUTRAM write port (combinational)
//   ram_rad/ram_do                LUTRAM asynchronous read port
//   count, full, empty, afull, ovf  occupancy and status flags
module lutram_fifo_ctrl #(
  parameter int unsigned AFULL_LEVEL = 12
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic [3:0] ram_wad,
  output logic [3:0] ram_di,
  output logic       ram_wre,
  output logic [3:0] ram_rad,
  input  logic [3:0] ram_do,
  output logic [4:0] count,
  output logic       full,
  output logic       empty,
  output logic       afull,
  output logic       ovf
);

  localparam logic [4:0] DEPTH    = 5'd16;
  localparam logic [4:0] AFULL_TH = 5'(AFULL_LEVEL);

  logic [3:0] wr_ptr, wr_ptr_nxt;
  logic [3:0] rd_ptr, rd_ptr_nxt;
  logic [4:0] count_q, count_nxt;
  logic       full_q, empty_q, afull_q, ovf_q;
  logic       wr_fire, rd_fire;

  // Handshakes depend only on registered flags, so there is no path from
  // out_ready to in_ready: a slot freed while full is writable next cycle.
  assign in_ready  = ~full_q;
  assign out_valid = ~empty_q;
  assign wr_fire   = in_valid & in_ready;
  assign rd_fire   = out_valid & out_ready;

  // rd_ptr == wr_ptr with a write only happens when empty, and then
  // out_valid is low, so out_data never shows the in-flight write.
  assign ram_wad  = wr_ptr;
  assign ram_di   = in_data;
  assign ram_wre  = wr_fire & ~RST;
  assign ram_rad  = rd_ptr;
  assign out_data = ram_do;

  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign afull = afull_q;
  assign ovf   = ovf_q;

  // Next-state pointers and occupancy. Flush wins over any concurrent
  // transfer; a write in the flush cycle may still reach the RAM but the
  // pointers reset past it, so it is unreachable.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count_q;
    if (flush) begin
      wr_ptr_nxt = 4'd0;
      rd_ptr_nxt = 4'd0;
      count_nxt  = 5'd0;
    end else begin
      if (wr_fire) wr_ptr_nxt = wr_ptr + 4'd1;
      if (rd_fire) rd_ptr_nxt = rd_ptr + 4'd1;
      case ({wr_fire, rd_fire})
        2'b10:   count_nxt = count_q + 5'd1;
        2'b01:   count_nxt = count_q - 5'd1;
        default: count_nxt = count_q;
      endcase
    end
  end

  // Status flags are decoded from the next count and registered, so they
  // come straight from flops and cannot glitch within a cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr  <= 4'd0;
      rd_ptr  <= 4'd0;
      count_q <= 5'd0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      count_q <= count_nxt;
      full_q  <= (count_nxt == DEPTH);
      empty_q <= (count_nxt == 5'd0);
      afull_q <= (count_nxt >= AFULL_TH);
      // Sticky: only RST clears it, flush leaves it alone.
      if (in_valid && full_q) ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lutram_fifo_ctrl.sv
// Purpose: self-checking bench for lutram_fifo_ctrl with a behavioural LUTRAM and queue-based reference.
// Latency: inputs driven on the falling edge, outputs compared 1 ns later, reference advanced on the rising edge.
// Backpressure: stimulus exercises full/empty, flush and reset mid-stream under random valid/ready.
module tb_lutram_fifo_ctrl;

  localparam int AFL = 12;

  logic       CLK;
  logic       RST;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [3:0] ram_wad;
  logic [3:0] ram_di;
  logic       ram_wre;
  logic [3:0] ram_rad;
  logic [3:0] ram_do;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       afull;
  logic       ovf;

  lutram_fifo_ctrl #(.AFULL_LEVEL(AFL)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ram_wad(ram_wad), .ram_di(ram_di), .ram_wre(ram_wre),
    .ram_rad(ram_rad), .ram_do(ram_do),
    .count(count), .full(full), .empty(empty), .afull(afull), .ovf(ovf)
  );

  // Behavioural 16x4 LUTRAM: synchronous write on CLK, asynchronous read.
  logic [3:0] mem [16];
  always @(posedge CLK) if (ram_wre) mem[ram_wad] <= ram_di;
  assign ram_do = mem[ram_rad];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: FIFO contents as a queue, addresses as counts of accepted ops mod 16.
  bit [3:0] q[$];
  bit       m_ovf;
  int       m_wr, m_rd;
  bit       model_on;

  int n_pass, n_total;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic compare_model();
    int sz;
    sz = q.size();
    chk("m_count",    int'(count),     sz);
    chk("m_empty",    int'(empty),     int'(sz == 0));
    chk("m_full",     int'(full),      int'(sz == 16));
    chk("m_afull",    int'(afull),     int'(sz >= AFL));
    chk("m_out_valid", int'(out_valid), int'(sz != 0));
    chk("m_in_ready", int'(in_ready),  int'(sz < 16));
    chk("m_ovf",      int'(ovf),       int'(m_ovf));
    chk("m_ram_wre",  int'(ram_wre),   int'(in_valid && sz < 16 && !RST));
    chk("m_ram_wad",  int'(ram_wad),   m_wr);
    chk("m_ram_di",   int'(ram_di),    int'(in_data));
    chk("m_ram_rad",  int'(ram_rad),   m_rd);
    if (sz != 0) chk("m_out_data", int'(out_data), int'(q[0]));
  endtask

  task automatic model_update();
    int sz;
    bit wr, rd;
    if (RST) begin
      q.delete();
      m_ovf = 1'b0;
      m_wr = 0;
      m_rd = 0;
    end else begin
      sz = q.size();
      wr = in_valid && sz < 16;
      rd = out_ready && sz > 0;
      if (in_valid && sz == 16) m_ovf = 1'b1;
      if (flush) begin
        q.delete();
        m_wr = 0;
        m_rd = 0;
      end else begin
        if (rd) begin
          void'(q.pop_front());
          m_rd = (m_rd + 1) % 16;
        end
        if (wr) begin
          q.push_back(in_data);
          m_wr = (m_wr + 1) % 16;
        end
      end
    end
  endtask

  task automatic set_inputs(input bit r, input bit f, input bit v, input bit [3:0] d, input bit o);
    @(negedge CLK);
    RST = r; flush = f; in_valid = v; in_data = d; out_ready = o;
    #1;
    if (model_on) compare_model();
  endtask

  task automatic clock_edge();
    @(posedge CLK);
    model_update();
  endtask

  task automatic step(input bit r, input bit f, input bit v, input bit [3:0] d, input bit o);
    set_inputs(r, f, v, d, o);
    clock_edge();
  endtask

  typedef struct {
    bit       rst, fl, iv;
    bit [3:0] d;
    bit       ordy;
    int       e_count;
    bit       e_ovalid;
    bit [3:0] e_odata;
    bit       e_empty, e_irdy, e_wre;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int piv, pord;
    n_pass = 0; n_total = 0; model_on = 1'b0;
    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));

    // Expected values are what is visible before the edge that consumes the inputs.
    tbl[0] = '{1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 4'h5, 1'b0, 1, 1'b1, 4'hA, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 4'h7, 1'b0, 2, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0};

    // Power-up reset; state is unknown until the first reset edge.
    step(1, 0, 1, 4'hF, 0);
    model_on = 1'b1;
    set_inputs(1, 0, 1, 4'hF, 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_afull", int'(afull), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_ram_wre", int'(ram_wre), 0);
    clock_edge();

    // Basic write/read, reset mid-stream, no stale data afterwards.
    for (int i = 0; i < 8; i++) begin
      set_inputs(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].e_count);
      chk($sformatf("tbl%0d_out_valid", i), int'(out_valid), int'(tbl[i].e_ovalid));
      if (tbl[i].e_ovalid) chk($sformatf("tbl%0d_out_data", i), int'(out_data), int'(tbl[i].e_odata));
      chk($sformatf("tbl%0d_empty", i), int'(empty), int'(tbl[i].e_empty));
      chk($sformatf("tbl%0d_in_ready", i), int'(in_ready), int'(tbl[i].e_irdy));
      chk($sformatf("tbl%0d_ram_wre", i), int'(ram_wre), int'(tbl[i].e_wre));
      clock_edge();
    end

    // Fill 0x0..0xF with no reads; afull from 12, full at 16, 17th offer sets ovf.
    for (int i = 0; i < 16; i++) begin
      set_inputs(0, 0, 1, 4'(i), 0);
      chk("fill_count", int'(count), i);
      chk("fill_afull", int'(afull), int'(i >= 12));
      clock_edge();
    end
    set_inputs(0, 0, 1, 4'h9, 0);
    chk("full_flag", int'(full), 1);
    chk("full_in_ready", int'(in_ready), 0);
    chk("full_afull", int'(afull), 1);
    chk("full_ovf_pre", int'(ovf), 0);
    chk("full_wre", int'(ram_wre), 0);
    clock_edge();
    set_inputs(0, 0, 0, 4'h0, 0);
    chk("ovf_set", int'(ovf), 1);
    chk("ovf_count", int'(count), 16);
    clock_edge();

    // Full with read and write offered together: only the read happens.
    set_inputs(0, 0, 1, 4'h6, 1);
    chk("fullrw_head", int'(out_data), 0);
    chk("fullrw_wre", int'(ram_wre), 0);
    clock_edge();
    set_inputs(0, 0, 1, 4'h6, 0);
    chk("fullrw_count15", int'(count), 15);
    chk("fullrw_in_ready", int'(in_ready), 1);
    chk("fullrw_wre2", int'(ram_wre), 1);
    clock_edge();
    set_inputs(0, 0, 0, 4'h0, 0);
    chk("fullrw_count16", int'(count), 16);
    clock_edge();

    // Drain to 7 words, then flush with a concurrent write; ovf must survive.
    for (int i = 0; i < 9; i++) step(0, 0, 0, 4'h0, 1);
    set_inputs(0, 1, 1, 4'h3, 1);
    chk("preflush_count", int'(count), 7);
    clock_edge();
    set_inputs(0, 0, 1, 4'hA, 0);
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);
    chk("flush_out_valid", int'(out_valid), 0);
    chk("flush_ovf_kept", int'(ovf), 1);
    clock_edge();
    set_inputs(0, 0, 1, 4'h2, 1);
    chk("postflush_first", int'(out_data), 10);
    clock_edge();
    set_inputs(0, 0, 0, 4'h0, 1);
    chk("postflush_second", int'(out_data), 2);
    clock_edge();

    // Steady state at count 5 with both pointers wrapping repeatedly.
    step(1, 0, 0, 4'h0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 4'(i), 0);
    for (int k = 0; k < 40; k++) begin
      set_inputs(0, 0, 1, 4'((k + 5) % 16), 1);
      chk("steady_count", int'(count), 5);
      chk("steady_data", int'(out_data), k % 16);
      clock_edge();
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 4'h0, 1);

    // Random traffic in phases biased toward empty, balanced and full.
    piv = 50; pord = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 50 == 0) begin
        case ($urandom_range(0, 2))
          0: piv = 20;
          1: piv = 50;
          default: piv = 90;
        endcase
        case ($urandom_range(0, 2))
          0: pord = 10;
          1: pord = 50;
          default: pord = 90;
        endcase
      end
      step(($urandom_range(0, 127) == 0), ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 99) < piv), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 99) < pord));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
